clz_seq_ctrl: RTL

//   Sequencer that counts leading zeros of a wide operand with one narrow clz unit.
//   It time-multiplexes that unit over the operand's words, most significant word first.

---
 rtl/clz_seq_ctrl_pkg.sv | 28 ++
 rtl/clz_seq_ctrl_clz.sv | 29 ++
 rtl/clz_seq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/clz_seq_ctrl_pkg.sv
// clz_seq_ctrl_pkg
//   Shared definitions for the leading-zero-count sequencer.
//   This package contains:
//     state_t - the sequencer state encoding. Encoding 2'd3 is unused
//               and recovers to S_IDLE.
//     clog2   - ceiling log2. It sizes the count, the clz output and
//               the word index.
package clz_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/clz_seq_ctrl_clz.sv
// clz
//   Combinational leading-zero counter for one word.
//   Ports:
//     in    [bits_in]        word to scan; bit bits_in-1 is the MSB
//     out   [clog2(bits_in)] number of leading zeros; 0 when in is zero
//     valid                  1 when in is non-zero, which means out is meaningful
module clz
   import clz_seq_ctrl_pkg::*;
#(
   parameter int bits_in = 8
) (
   input  logic [bits_in-1:0]        in,
   output logic [clog2(bits_in)-1:0] out,
   output logic                      valid
);

   localparam int OW = clog2(bits_in);

   // The scan runs upward, so the highest set bit is the last one written.
   always_comb begin
      out = '0;
      for (int unsigned i = 0; i < bits_in; i++) begin
         if (in[i]) out = OW'(bits_in - 1 - i);
      end
   end

   assign valid = |in;

endmodule

// File: rtl/clz_seq_ctrl.sv
// clz_seq_ctrl
//   Counts the leading zeros of a WORD*NWORDS-bit operand. It does this with
//   one WORD-wide clz unit. The unit scans the words most significant first,
//   one word per cycle, and stops at the first non-zero word.
//   Ports:
//     clk, rst   clock; asynchronous active-high reset
//     in_valid   operand offered          in_ready  operand can be accepted
//     in_data    operand [W], MSB is bit W-1
//     flush      synchronous abort of the current operation
//     out_valid  result available         out_ready consumer takes the result
//     out_count  leading-zero count [CW], range 0..W
//     out_zero   1 when the operand was all zero
module clz_seq_ctrl
   import clz_seq_ctrl_pkg::*;
#(
   parameter  int WORD   = 8,
   parameter  int NWORDS = 4,
   localparam int W      = WORD * NWORDS,
   localparam int CW     = clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_count,
   output logic          out_zero
);

   localparam int ZW = clog2(WORD);
   localparam int IW = (NWORDS > 1) ? clog2(NWORDS) : 1;

   state_t          state, state_nxt;
   logic [W-1:0]    opnd, opnd_nxt;
   logic [IW-1:0]   idx, idx_nxt;
   logic [CW-1:0]   acc, acc_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic            zero, zero_nxt;
   logic            take;

   logic [WORD-1:0] cur_word;
   logic [ZW-1:0]   clz_out;
   logic            clz_valid;

   assign cur_word = opnd[idx*WORD +: WORD];

   clz #(.bits_in(WORD)) u_clz (
      .in    (cur_word),
      .out   (clz_out),
      .valid (clz_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         opnd  <= '0;
         idx   <= '0;
         acc   <= '0;
         count <= '0;
         zero  <= 1'b0;
      end else begin
         state <= state_nxt;
         opnd  <= opnd_nxt;
         idx   <= idx_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         zero  <= zero_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      opnd_nxt  = opnd;
      idx_nxt   = idx;
      acc_nxt   = acc;
      count_nxt = count;
      zero_nxt  = zero;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      take      = 1'b0;

      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            take     = in_valid;
         end
         S_SCAN: begin
            if (clz_valid) begin
               count_nxt = acc + CW'(clz_out);
               zero_nxt  = 1'b0;
               state_nxt = S_DONE;
            end else if (idx == '0) begin
               count_nxt = CW'(W);
               zero_nxt  = 1'b1;
               state_nxt = S_DONE;
            end else begin
               acc_nxt = acc + CW'(WORD);
               idx_nxt = idx - IW'(1);
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            // The result handshake and the next accept happen in the same
            // cycle, so back-to-back operands never pass through IDLE.
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) take = 1'b1;
               else          state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (take) begin
         opnd_nxt  = in_data;
         idx_nxt   = IW'(NWORDS - 1);
         acc_nxt   = '0;
         state_nxt = S_SCAN;
      end

      // flush overrides both accept and the output handshake. All datapath
      // registers are restored so that an operand offered in the same cycle
      // leaves no trace.
      if (flush) begin
         state_nxt = S_IDLE;
         opnd_nxt  = opnd;
         idx_nxt   = idx;
         acc_nxt   = acc;
         count_nxt = count;
         zero_nxt  = zero;
      end
   end

   assign out_count = count;
   assign out_zero  = zero;

endmodule
